csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter XLEN, default `XLEN (32), datapath width.
REQ-002 Parameter HARTID, default 0, value returned by mhartid.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 csr_valid  in  1  CSR request this cycle; driven from the decoder's is_csr.
REQ-006 csr_w / csr_set / csr_clr  in  1 each  operation select; exactly one is set when csr_valid=1.
REQ-007 csr_zimm  in  1  1: the source operand is zimm; 0: the source operand is rs1_data.
REQ-008 csr_addr  in  12  CSR address (inst[31:20]).
REQ-009 rs1_data  in  XLEN  register source operand.
REQ-010 zimm  in  5  immediate source operand (inst[19:15]), zero-extended.
REQ-011 src_zero  in  1  rs1 index (or zimm) equals 0.
REQ-012 retire  in  1  one instruction retired this cycle.
REQ-013 rdata  out  XLEN  old CSR value, for rd writeback.
REQ-014 resp_valid  out  1  rdata/illegal are valid.
REQ-015 illegal  out  1  the request was rejected.

Function
REQ-016 Implemented CSRs: mstatus 0x300, misa 0x301, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mhartid 0xF14.
REQ-017 Every request is accepted; the block has no stall.
REQ-018 Response timing: resp_valid=1 exactly one cycle after a cycle with csr_valid=1; otherwise resp_valid=0.
REQ-019 Read value: rdata is the CSR value before the write, registered at the accepting edge.
REQ-020 Write timing: the write takes effect at the same edge, so a back-to-back request sees the new value.
REQ-021 Source operand: src = csr_zimm ? {27'b0, zimm} : rs1_data.
REQ-022 New value by operation:
  - csrrw: src
  - csrrs: old | src
  - csrrc: old & ~src
REQ-023 Write attempt:
  - csr_w always attempts a write.
  - set/clr attempt a write only when src_zero=0.
  - set/clr with src_zero=1 is a pure read and has no side effect.
REQ-024 A request is illegal when any of the following holds:
  - the address is unimplemented;
  - the op select is not one-hot;
  - a write is attempted to a read-only address (csr_addr[11:10]==2'b11).
REQ-025 An illegal request produces no state change, rdata=0 and illegal=1 in the response cycle.
REQ-026 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; all other bits read 0.
REQ-027 misa is read-only, 32'h4000_0100; writes are ignored and are not illegal.
REQ-028 mtvec and mepc: bits[1:0] are hardwired to 0.
REQ-029 mscratch and mcause: all XLEN bits are read/write.
REQ-030 mcycle: 64-bit counter, incremented every cycle while rst=0; wraps from 2^64-1 to 0.
REQ-031 minstret: 64-bit counter, incremented on cycles with retire=1; wraps.
REQ-032 Counter write priority: a CSR write to a counter half beats the increment in that cycle.
REQ-033 Low-half write: the low half is loaded and the high half holds.
REQ-034 High-half write: the high half is loaded, the low half still increments, and carry out of the low half is dropped that cycle.
REQ-035 Read-only aliases: cycle/cycleh/instret/instreth read the same values as the machine counters.
REQ-036 mhartid reads HARTID.

Reset
REQ-037 On rst assertion, asynchronously clear:
  - resp_valid, illegal and rdata;
  - mstatus, mtvec, mepc, mcause and mscratch;
  - both counters.
REQ-038 Counters resume on the first edge after rst deasserts; the first increment yields mcycle=1.
REQ-039 rst asserted mid-request: the request is discarded and no response is produced.

Structure
REQ-040 The CSR address localparams, the mstatus bit positions and the misa value live in the shared package csr_pkg; XLEN comes from common.sv.
REQ-041 Each 64-bit counter is an instance of sub-module csr_counter64, with inputs inc, wr_lo, wr_hi and wdata, and a 64-bit count output.

Verification
REQ-042 Write then read: csrrw mscratch with rs1_data=0xDEADBEEF -> rdata=0; a following csrrs with src_zero=1 -> rdata=0xDEADBEEF.
REQ-043 Set/clear: csrrsi mstatus zimm=0x8 -> mstatus=0x8; then csrrci zimm=0x8 -> rdata=0x8, mstatus=0; then csrrw 0xFFFFFFFF -> mstatus reads 0x88.
REQ-044 Illegal: csrrw cycle (0xC00) -> illegal=1 and counter unaffected; csrrs cycle with src_zero=1 -> illegal=0; read of 0x7C0 -> illegal=1, rdata=0.
REQ-045 Counter wrap: write mcycle=0xFFFFFFFF and mcycleh=0 on the same-cycle sequence -> mcycleh reads 1 two cycles later; an all-ones counter wraps to 0.
REQ-046 Write priority: retire=1 together with csrrw minstret=5 -> minstret reads 5 next request, not 6.
REQ-047 Reset: assert rst during a csr_valid cycle -> resp_valid=0 and all CSRs read reset values after release.

Source files
------------

// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, mstatus field positions and the fixed misa value.
package csr_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrInstreth  = 12'hC82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  localparam logic [31:0] MisaValue = 32'h4000_0100;

  typedef enum logic [1:0] {OpWrite, OpSet, OpClear} csr_op_e;

  // True for every address this file answers.
  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CsrMstatus, CsrMisa, CsrMtvec, CsrMscratch, CsrMepc, CsrMcause,
      CsrMcycle, CsrMinstret, CsrMcycleh, CsrMinstreth,
      CsrCycle, CsrInstret, CsrCycleh, CsrInstreth, CsrMhartid: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/common.sv
// Shared build-wide macros.
`ifndef XLEN
`define XLEN 32
`endif

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [31:0] lo_q, lo_d, hi_q, hi_d;

  // A write beats the increment; a high-half write keeps the low half counting but drops its carry.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_lo_i) begin
      lo_d = wdata_i;
    end else if (wr_hi_i) begin
      hi_d = wdata_i;
      lo_d = lo_q + {31'b0, inc_i};
    end else begin
      {hi_d, lo_d} = {hi_q, lo_q} + {63'b0, inc_i};
    end
  end

  // Count state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: single-cycle read-modify-write with a registered response.
`ifndef XLEN
`define XLEN 32
`endif

module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned XLEN   = `XLEN,
  parameter int unsigned HARTID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid_i,
  input  logic            csr_w_i,
  input  logic            csr_set_i,
  input  logic            csr_clr_i,
  input  logic            csr_zimm_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      zimm_i,
  input  logic            src_zero_i,
  input  logic            retire_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            resp_valid_o,
  output logic            illegal_o
);

  localparam logic [XLEN-1:0] MstatusMask =
      (XLEN'(1) << MstatusMieBit) | (XLEN'(1) << MstatusMpieBit);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            resp_valid_q, illegal_q, illegal_d;

  logic [XLEN-1:0] src, old_val, new_val;
  logic            wr_attempt, req_illegal, do_write;
  logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic [63:0]     mcycle, minstret;
  csr_op_e         op;

  // Current value of the addressed CSR; aliases share the machine counters.
  always_comb begin
    old_val = '0;
    case (csr_addr_i)
      CsrMstatus:                old_val = mstatus_q;
      CsrMisa:                   old_val = XLEN'(MisaValue);
      CsrMtvec:                  old_val = mtvec_q;
      CsrMscratch:               old_val = mscratch_q;
      CsrMepc:                   old_val = mepc_q;
      CsrMcause:                 old_val = mcause_q;
      CsrMcycle,   CsrCycle:     old_val = XLEN'(mcycle[31:0]);
      CsrMcycleh,  CsrCycleh:    old_val = XLEN'(mcycle[63:32]);
      CsrMinstret, CsrInstret:   old_val = XLEN'(minstret[31:0]);
      CsrMinstreth, CsrInstreth: old_val = XLEN'(minstret[63:32]);
      CsrMhartid:                old_val = XLEN'(HARTID);
      default:                   old_val = '0;
    endcase
  end

  // Request decode: operand, legality and the value the operation would write.
  always_comb begin
    src         = csr_zimm_i ? XLEN'(zimm_i) : rs1_data_i;
    wr_attempt  = csr_w_i | ((csr_set_i | csr_clr_i) & ~src_zero_i);
    req_illegal = !csr_implemented(csr_addr_i) ||
                  !$onehot({csr_w_i, csr_set_i, csr_clr_i}) ||
                  (wr_attempt && (csr_addr_i[11:10] == 2'b11));
    do_write    = csr_valid_i && !req_illegal && wr_attempt;
    op          = csr_set_i ? OpSet : (csr_clr_i ? OpClear : OpWrite);
    case (op)
      OpSet:   new_val = old_val | src;
      OpClear: new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  // Next state of the plain registers and write strobes for the counter halves.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    cyc_wr_lo  = 1'b0;
    cyc_wr_hi  = 1'b0;
    ins_wr_lo  = 1'b0;
    ins_wr_hi  = 1'b0;
    if (do_write) begin
      case (csr_addr_i)
        CsrMstatus:   mstatus_d  = new_val & MstatusMask;
        CsrMtvec:     mtvec_d    = new_val & AlignMask;
        CsrMscratch:  mscratch_d = new_val;
        CsrMepc:      mepc_d     = new_val & AlignMask;
        CsrMcause:    mcause_d   = new_val;
        CsrMcycle:    cyc_wr_lo  = 1'b1;
        CsrMcycleh:   cyc_wr_hi  = 1'b1;
        CsrMinstret:  ins_wr_lo  = 1'b1;
        CsrMinstreth: ins_wr_hi  = 1'b1;
        default:      ; // misa writes are silently dropped
      endcase
    end
    illegal_d = illegal_q;
    rdata_d   = rdata_q;
    if (csr_valid_i) begin
      illegal_d = req_illegal;
      rdata_d   = req_illegal ? '0 : old_val;
    end
  end

  // Register state and the one-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q    <= '0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mscratch_q   <= '0;
      rdata_q      <= '0;
      illegal_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      mstatus_q    <= mstatus_d;
      mtvec_q      <= mtvec_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mscratch_q   <= mscratch_d;
      rdata_q      <= rdata_d;
      illegal_q    <= illegal_d;
      resp_valid_q <= csr_valid_i;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (cyc_wr_lo),
    .wr_hi_i (cyc_wr_hi),
    .wdata_i (new_val[31:0]),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire_i),
    .wr_lo_i (ins_wr_lo),
    .wr_hi_i (ins_wr_hi),
    .wdata_i (new_val[31:0]),
    .count_o (minstret)
  );

  assign rdata_o      = rdata_q;
  assign resp_valid_o = resp_valid_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// Randomized and directed bench for csr_file against a behavioural CSR model.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid, csr_w, csr_set, csr_clr, csr_zimm, src_zero, retire;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, rdata;
  logic [4:0]  zimm;
  logic        resp_valid, illegal;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_cycle, m_instret;

  // Last observed / expected response
  logic [31:0] o_rdata, e_rdata;
  logic        o_ill, e_ill, o_rv;

  localparam logic [2:0] OpW = 3'b100, OpS = 3'b010, OpC = 3'b001;

  always #5 clk = ~clk;

  csr_file #(.XLEN(32), .HARTID(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_valid_i  (csr_valid),
    .csr_w_i      (csr_w),
    .csr_set_i    (csr_set),
    .csr_clr_i    (csr_clr),
    .csr_zimm_i   (csr_zimm),
    .csr_addr_i   (csr_addr),
    .rs1_data_i   (rs1_data),
    .zimm_i       (zimm),
    .src_zero_i   (src_zero),
    .retire_i     (retire),
    .rdata_o      (rdata),
    .resp_valid_o (resp_valid),
    .illegal_o    (illegal)
  );

  task automatic model_reset();
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
    v = 0;
    case (a)
      12'h300: v = m_mstatus;
      12'h301: v = 32'h4000_0100;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hF14: v = 32'd5;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // One clock cycle: drive after a falling edge, sample at the next falling edge, advance model.
  task automatic step(input logic v, input logic [2:0] op, input logic zs, input logic [11:0] a,
                      input logic [31:0] rs1, input logic [4:0] zi, input logic sz,
                      input logic rt);
    logic [31:0] old, src, wv;
    logic        impl, attempt, ill, wr, one_hot;
    csr_valid = v; {csr_w, csr_set, csr_clr} = op; csr_zimm = zs; csr_addr = a;
    rs1_data = rs1; zimm = zi; src_zero = sz; retire = rt;
    src     = zs ? {27'b0, zi} : rs1;
    impl    = model_read(a, old);
    one_hot = (op == OpW) || (op == OpS) || (op == OpC);
    attempt = op[2] || ((op[1] || op[0]) && !sz);
    ill     = !impl || !one_hot || (attempt && a[11:10] == 2'b11);
    e_ill   = ill;
    e_rdata = ill ? 32'h0 : old;
    wr      = v && !ill && attempt;
    wv      = op[2] ? src : (op[1] ? (old | src) : (old & ~src));
    @(negedge clk);
    o_rv = resp_valid; o_rdata = rdata; o_ill = illegal;
    if (wr && a == 12'hB00)      m_cycle[31:0] = wv;
    else if (wr && a == 12'hB80) begin
      m_cycle[63:32] = wv; m_cycle[31:0] = m_cycle[31:0] + 32'd1;
    end else m_cycle = m_cycle + 64'd1;
    if (wr && a == 12'hB02)      m_instret[31:0] = wv;
    else if (wr && a == 12'hB82) begin
      m_instret[63:32] = wv; m_instret[31:0] = m_instret[31:0] + {31'b0, rt};
    end else m_instret = m_instret + {63'b0, rt};
    if (wr) begin
      case (a)
        12'h300: m_mstatus  = wv & 32'h88;
        12'h305: m_mtvec    = wv & ~32'h3;
        12'h340: m_mscratch = wv;
        12'h341: m_mepc     = wv & ~32'h3;
        12'h342: m_mcause   = wv;
        default: ;
      endcase
    end
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, OpS, 1'b0, a, 32'h0, 5'h0, 1'b1, 1'b0);
  endtask

  task automatic wrr(input logic [11:0] a, input logic [31:0] d, input logic rt);
    step(1'b1, OpW, 1'b0, a, d, 5'h0, 1'b0, rt);
  endtask

  task automatic idle(input logic rt);
    step(1'b0, 3'b000, 1'b0, 12'h0, 32'h0, 5'h0, 1'b0, rt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    csr_valid = 0; csr_w = 0; csr_set = 0; csr_clr = 0; csr_zimm = 0; csr_addr = 0;
    rs1_data = 0; zimm = 0; src_zero = 0; retire = 0;
    repeat (3) @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    rst = 1'b0;
    model_reset();
    rd(12'hB00);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL first_cycle0: got %h want 0", o_rdata); end
    total++; if (o_rv !== 1'b1) begin bad++; $display("FAIL first_resp_valid: got %b want 1", o_rv); end
    rd(12'hB00);
    total++; if (o_rdata !== 32'h1) begin bad++; $display("FAIL first_cycle1: got %h want 1", o_rdata); end
    idle(1'b0);
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL idle_resp_valid: got %b want 0", o_rv); end
  endtask

  task automatic test_write_read();
    wrr(12'h340, 32'hDEADBEEF, 1'b0);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL wr_old: got %h want 0", o_rdata); end
    rd(12'h340);
    total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_new: got %h want deadbeef", o_rdata); end
    total++; if (o_ill !== 1'b0) begin bad++; $display("FAIL rd_legal: got %b want 0", o_ill); end
  endtask

  task automatic test_set_clear();
    step(1'b1, OpS, 1'b1, 12'h300, 32'h0, 5'h8, 1'b0, 1'b0);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL csrrsi_old: got %h want 0", o_rdata); end
    step(1'b1, OpC, 1'b1, 12'h300, 32'h0, 5'h8, 1'b0, 1'b0);
    total++; if (o_rdata !== 32'h8) begin bad++; $display("FAIL csrrci_old: got %h want 8", o_rdata); end
    wrr(12'h300, 32'hFFFFFFFF, 1'b0);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL mstatus_cleared: got %h want 0", o_rdata); end
    rd(12'h300);
    total++; if (o_rdata !== 32'h88) begin bad++; $display("FAIL mstatus_mask: got %h want 88", o_rdata); end
    wrr(12'h305, 32'hFFFFFFFF, 1'b0);
    rd(12'h305);
    total++; if (o_rdata !== 32'hFFFFFFFC) begin bad++; $display("FAIL mtvec_align: got %h want fffffffc", o_rdata); end
    wrr(12'h341, 32'h12345677, 1'b0);
    rd(12'h341);
    total++; if (o_rdata !== 32'h12345674) begin bad++; $display("FAIL mepc_align: got %h want 12345674", o_rdata); end
    wrr(12'h301, 32'h0, 1'b0);
    total++; if (o_ill !== 1'b0) begin bad++; $display("FAIL misa_wr_legal: got %b want 0", o_ill); end
    rd(12'h301);
    total++; if (o_rdata !== 32'h40000100) begin bad++; $display("FAIL misa_value: got %h want 40000100", o_rdata); end
  endtask

  task automatic test_illegal();
    wrr(12'hC00, 32'h55, 1'b0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL wr_cycle_ill: got %b want 1", o_ill); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL wr_cycle_rdata: got %h want 0", o_rdata); end
    rd(12'hC00);
    total++; if (o_ill !== 1'b0) begin bad++; $display("FAIL rd_cycle_legal: got %b want 0", o_ill); end
    total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rd_cycle_value: got %h want %h", o_rdata, e_rdata); end
    rd(12'h7C0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL unimpl_ill: got %b want 1", o_ill); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL unimpl_rdata: got %h want 0", o_rdata); end
    step(1'b1, OpS, 1'b0, 12'hC00, 32'h1, 5'h0, 1'b0, 1'b0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL set_ro_ill: got %b want 1", o_ill); end
    wrr(12'hF14, 32'h9, 1'b0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL wr_hartid_ill: got %b want 1", o_ill); end
    rd(12'hF14);
    total++; if (o_rdata !== 32'h5) begin bad++; $display("FAIL hartid: got %h want 5", o_rdata); end
    step(1'b1, 3'b110, 1'b0, 12'h340, 32'h1234, 5'h0, 1'b0, 1'b0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL multi_op_ill: got %b want 1", o_ill); end
    step(1'b1, 3'b000, 1'b0, 12'h340, 32'h0, 5'h0, 1'b0, 1'b0);
    total++; if (o_ill !== 1'b1) begin bad++; $display("FAIL no_op_ill: got %b want 1", o_ill); end
    rd(12'h340);
    total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ill_no_effect: got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_counter_wrap();
    wrr(12'hB80, 32'h0, 1'b0);
    wrr(12'hB00, 32'hFFFFFFFF, 1'b0);
    idle(1'b0);
    rd(12'hB80);
    total++; if (o_rdata !== 32'h1) begin bad++; $display("FAIL mcycleh_carry: got %h want 1", o_rdata); end
    wrr(12'hB80, 32'hFFFFFFFF, 1'b0);
    wrr(12'hB00, 32'hFFFFFFFF, 1'b0);
    rd(12'hB80);
    total++; if (o_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL mcycle_ones: got %h want ffffffff", o_rdata); end
    rd(12'hB00);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL mcycle_wrap_lo: got %h want 0", o_rdata); end
    rd(12'hC80);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL mcycle_wrap_hi: got %h want 0", o_rdata); end
    wrr(12'hB82, 32'hFFFFFFFF, 1'b0);
    wrr(12'hB02, 32'hFFFFFFFF, 1'b0);
    idle(1'b1);
    rd(12'hC02);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL instret_wrap_lo: got %h want 0", o_rdata); end
    rd(12'hB82);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL instret_wrap_hi: got %h want 0", o_rdata); end
  endtask

  task automatic test_write_priority();
    wrr(12'hB02, 32'h5, 1'b1);
    rd(12'hB02);
    total++; if (o_rdata !== 32'h5) begin bad++; $display("FAIL wr_beats_inc: got %h want 5", o_rdata); end
    idle(1'b1);
    rd(12'hC02);
    total++; if (o_rdata !== 32'h6) begin bad++; $display("FAIL instret_resume: got %h want 6", o_rdata); end
  endtask

  task automatic test_back_to_back();
    wrr(12'h342, 32'hA5A5_0F0F, 1'b0);
    wrr(12'h342, 32'h1234_5678, 1'b0);
    total++; if (o_rdata !== 32'hA5A50F0F) begin bad++; $display("FAIL b2b_first: got %h want a5a50f0f", o_rdata); end
    step(1'b1, OpC, 1'b0, 12'h342, 32'h0000_FFFF, 5'h0, 1'b0, 1'b0);
    total++; if (o_rdata !== 32'h12345678) begin bad++; $display("FAIL b2b_second: got %h want 12345678", o_rdata); end
    rd(12'h342);
    total++; if (o_rdata !== 32'h12340000) begin bad++; $display("FAIL b2b_clear: got %h want 12340000", o_rdata); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'hF15};
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic        v, zs, sz, rt;
      logic [31:0] rs1;
      logic [4:0]  zi;
      int          r;
      r  = $urandom_range(0, 15);
      op = (r < 5) ? OpW : (r < 10) ? OpS : (r < 15) ? OpC : 3'($urandom_range(0, 7));
      zs = 1'($urandom_range(0, 1));
      zi = 5'($urandom);
      if ($urandom_range(0, 3) == 0) zi = 5'h0;
      rs1 = $urandom;
      if (zs) sz = (zi == 5'h0);
      else begin
        sz = ($urandom_range(0, 3) == 0);
        if (sz) rs1 = 32'h0;
      end
      v  = ($urandom_range(0, 4) != 0);
      rt = 1'($urandom_range(0, 1));
      step(v, op, zs, addrs[$urandom_range(0, 17)], rs1, zi, sz, rt);
      total++; if (o_rv !== v) begin bad++; $display("FAIL rnd_resp_valid[%0d]: got %b want %b", i, o_rv, v); end
      if (v) begin
        total++; if (o_ill !== e_ill) begin bad++; $display("FAIL rnd_illegal[%0d]: got %b want %b", i, o_ill, e_ill); end
        total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o_rdata, e_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    wrr(12'h340, 32'h1111_2222, 1'b1);
    wrr(12'h300, 32'h8, 1'b1);
    csr_valid = 1'b1; {csr_w, csr_set, csr_clr} = OpW; csr_addr = 12'h342; rs1_data = 32'h77;
    #2 rst = 1'b1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_resp: got %b want 0", resp_valid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", rdata); end
    rst = 1'b0;
    model_reset();
    rd(12'hB00);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mcycle: got %h want 0", o_rdata); end
    rd(12'hB02);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_minstret: got %h want 0", o_rdata); end
    rd(12'h340);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mscratch: got %h want 0", o_rdata); end
    rd(12'h300);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mstatus: got %h want 0", o_rdata); end
    rd(12'h342);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mcause: got %h want 0", o_rdata); end
    rd(12'h305);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mtvec: got %h want 0", o_rdata); end
    rd(12'h341);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mepc: got %h want 0", o_rdata); end
    rd(12'hB80);
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL post_rst_mcycleh: got %h want 0", o_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_set_clear();
    test_illegal();
    test_counter_wrap();
    test_write_priority();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
